// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between two masters:
//     port 0 : multicycle CPU fetch/load/store path
//     port 1 : boot loader / debug master (program image writes, memory peeks)
//   Round-robin arbitration with an optional bounded bus lock. This lets one
//   master run back-to-back bursts without interleaving.
//
//   Optional build macro: MEM_ARB_PERF_CNT_EN
//     Adds the saturating 32-bit counters perf_gnt0, perf_gnt1 and perf_stall.
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata   request side of port X (0 or 1)
//   mX_gnt                      access of port X performed this cycle
//   mX_rvalid, mX_rdata         read return, one cycle after a read grant
//   mem_en/we/addr/wdata        RAM command (driven from the granted port)
//   mem_rdata                   RAM read data (valid one cycle after a read)
//   dbg_state                   FSM state: 0 = IDLE, 1 = OWN0, 2 = OWN1
//   perf_gnt0/1, perf_stall     performance counters (macro builds only)
//
// Handshake: mX_req acts as "valid" and mX_gnt acts as "ready". An access
// completes in the cycle where both are high. A requester keeps req, we, addr,
// wdata and lock stable until it sees gnt. gnt is combinational from the
// current inputs and the registered state. At most one gnt is high per cycle.
module mem_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_gnt0,
  output logic [31:0]       perf_gnt1,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;       // port that received the most recent grant
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               m0_rvalid_q, m1_rvalid_q;
  logic               lock_at_max;
  logic               force_rel;

  // The owner has used up its lock budget and the other port is waiting.
  // The waiting port takes the bus this cycle.
  assign lock_at_max = (lock_cnt_q == CNT_W'(MAX_LOCK));
  assign force_rel   = lock_at_max &&
                       (((state_q == ST_OWN0) && m1_req) ||
                        ((state_q == ST_OWN1) && m0_req));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;          // port 0 wins the first tie after reset
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (m0_gnt)      last_d = 1'b0;
    else if (m1_gnt) last_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        lock_cnt_d = '0;
        // Only the port that actually won can take ownership.
        if (m0_gnt && m0_lock) begin
          state_d    = ST_OWN0;
          lock_cnt_d = CNT_W'(1);
        end else if (m1_gnt && m1_lock) begin
          state_d    = ST_OWN1;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ST_OWN0: begin
        if (force_rel || !m0_lock) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (m1_req) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      ST_OWN1: begin
        if (force_rel || !m1_lock) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (m0_req) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Output logic: grants and RAM command mux
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && (!m1_req || last_q)) m0_gnt = 1'b1;
        else if (m1_req)                   m1_gnt = 1'b1;
      end
      ST_OWN0: begin
        // The owner does not block an otherwise idle bus.
        if (force_rel)   m1_gnt = 1'b1;
        else if (m0_req) m0_gnt = 1'b1;
        else if (m1_req) m1_gnt = 1'b1;
      end
      ST_OWN1: begin
        if (force_rel)   m0_gnt = 1'b1;
        else if (m1_req) m1_gnt = 1'b1;
        else if (m0_req) m0_gnt = 1'b1;
      end
      default: ;
    endcase

    mem_en    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Both ports see the RAM read bus. Consumers qualify it with their rvalid.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign dbg_state = state_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic stall;
  assign stall = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (m0_gnt && (perf_gnt0  != 32'hFFFF_FFFF)) perf_gnt0  <= perf_gnt0  + 32'd1;
      if (m1_gnt && (perf_gnt1  != 32'hFFFF_FFFF)) perf_gnt1  <= perf_gnt1  + 32'd1;
      if (stall  && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by a randomized phase. A behavioural model
//   (owner / last / lock budget as plain integers) predicts grants, the RAM
//   command and read returns. A shadow memory predicts read data. An
//   environment RAM model sits on the mem_* bus.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       perf_gnt0, perf_gnt1, perf_stall;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_stall(perf_stall)
`endif
  );

  // ---------------- environment RAM ----------------
  function automatic logic [DATA_W-1:0] init_word(input int a);
    return 32'hC0DE_0000 | (32'(a) & 32'h0000_FFFF);
  endfunction

  logic [DATA_W-1:0] ram   [0:511];
  bit                wr_ok [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[8:0]]   <= mem_wdata;
        wr_ok[mem_addr[8:0]] <= 1'b1;
      end else begin
        mem_rdata <= wr_ok[mem_addr[8:0]] ? ram[mem_addr[8:0]] : init_word(int'(mem_addr[8:0]));
      end
    end
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] shadow [0:511];
  int own  = -1;   // -1: nobody owns the bus, else owning port
  int last = 1;
  int cnt  = 0;
  bit exp_rv0 = 0, exp_rv1 = 0;
  bit exp_g0, exp_g1;
  logic obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [DATA_W-1:0] obs_rd0;
  logic [1:0] obs_state;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pm_g0 = '0, pm_g1 = '0, pm_st = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input bit rq, input bit we, input bit lk,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m0_req = rq; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input bit rq, input bit we, input bit lk,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m1_req = rq; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
  endtask

  task automatic new_txn(input int p);
    bit rq, we, lk;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    rq = ($urandom_range(0, 9) < 6);
    we = ($urandom_range(0, 1) == 1);
    lk = ($urandom_range(0, 2) == 0);
    a  = ADDR_W'($urandom_range(0, 31));
    d  = $urandom();
    if (p == 0) drive0(rq, we, lk, a, d);
    else        drive1(rq, we, lk, a, d);
  endtask

  // One clock cycle: predict at the negedge, check, then commit at the posedge.
  task automatic step();
    bit r[2], l[2], g[2];
    int win, n_own, n_cnt, x, o;
    bit e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [8:0] a9;
    @(negedge clk);
    r[0] = m0_req; r[1] = m1_req; l[0] = m0_lock; l[1] = m1_lock;
    g[0] = 0; g[1] = 0; win = -1; n_own = own; n_cnt = cnt;
    if (own < 0) begin
      if (r[0] && r[1]) win = (last == 0) ? 1 : 0;
      else if (r[0])    win = 0;
      else if (r[1])    win = 1;
      if (win >= 0 && l[win]) begin n_own = win; n_cnt = 1; end
    end else begin
      x = own; o = 1 - own;
      if (r[o] && cnt == MAX_LOCK) begin
        win = o; n_own = -1; n_cnt = 0;
      end else begin
        if (r[x])      win = x;
        else if (r[o]) win = o;
        if (!l[x])     begin n_own = -1; n_cnt = 0; end
        else if (r[o]) n_cnt = cnt + 1;
      end
    end
    if (win >= 0) g[win] = 1;
    exp_g0 = g[0]; exp_g1 = g[1];
    e_we = 0; e_addr = '0; e_wdata = '0;
    if (win == 0)      begin e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; end
    else if (win == 1) begin e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; end

    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_state = dbg_state;
    chk("m0_gnt", m0_gnt, g[0]);
    chk("m1_gnt", m1_gnt, g[1]);
    chk("mem_en", mem_en, g[0] | g[1]);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("dbg_state", dbg_state, (own < 0) ? 2'd0 : (own == 0) ? 2'd1 : 2'd2);
    chk("m0_rvalid", m0_rvalid, exp_rv0);
    chk("m1_rvalid", m1_rvalid, exp_rv1);
    if (exp_rv0 && exp_q0.size() > 0) chk("m0_rdata", m0_rdata, exp_q0.pop_front());
    if (exp_rv1 && exp_q1.size() > 0) chk("m1_rdata", m1_rdata, exp_q1.pop_front());
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_gnt0", perf_gnt0, pm_g0);
    chk("perf_gnt1", perf_gnt1, pm_g1);
    chk("perf_stall", perf_stall, pm_st);
`endif

    @(posedge clk);
    if (win >= 0) begin
      a9 = e_addr[8:0];
      if (e_we)      shadow[a9] = e_wdata;
      else if (!rst) begin
        if (win == 0) exp_q0.push_back(shadow[a9]);
        else          exp_q1.push_back(shadow[a9]);
      end
    end
    exp_rv0 = g[0] && !m0_we && !rst;
    exp_rv1 = g[1] && !m1_we && !rst;
    if (rst) begin
      own = -1; last = 1; cnt = 0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      own = n_own; cnt = n_cnt;
      if (win >= 0) last = win;
    end
`ifdef MEM_ARB_PERF_CNT_EN
    if (rst) begin
      pm_g0 = '0; pm_g1 = '0; pm_st = '0;
    end else begin
      if (g[0] && pm_g0 != 32'hFFFF_FFFF) pm_g0++;
      if (g[1] && pm_g1 != 32'hFFFF_FFFF) pm_g1++;
      if (((r[0] && !g[0]) || (r[1] && !g[1])) && pm_st != 32'hFFFF_FFFF) pm_st++;
    end
`endif
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    rst = 1'b1;
    drive0(0, 0, 0, '0, '0);
    drive1(0, 0, 0, '0, '0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_state_idle", obs_state, 2'd0);

    // Port 1 stores 0xDEADBEEF at 0x10, then port 0 reads it back alone.
    drive1(1, 1, 0, ADDR_W'(9'h010), 32'hDEAD_BEEF);
    step();
    drive1(0, 0, 0, '0, '0);
    drive0(1, 0, 0, ADDR_W'(9'h010), '0);
    step();
    chk("s1_m0_gnt", obs_g0, 1'b1);
    drive0(0, 0, 0, '0, '0);
    step();
    chk("s1_m0_rvalid", obs_rv0, 1'b1);
    chk("s1_m0_rdata", obs_rd0, 32'hDEAD_BEEF);
    chk("s1_m1_rvalid", obs_rv1, 1'b0);

    // Continuous reads from both ports right after reset alternate 0,1,0,1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive0(1, 0, 0, ADDR_W'($urandom_range(0, 31)), '0);
    drive1(1, 0, 0, ADDR_W'($urandom_range(0, 31)), '0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("s2_m0_gnt_%0d", i), obs_g0, (i % 2) == 0);
      chk($sformatf("s2_m1_gnt_%0d", i), obs_g1, (i % 2) == 1);
      if (exp_g0) drive0(1, 0, 0, ADDR_W'($urandom_range(0, 31)), '0);
      if (exp_g1) drive1(1, 0, 0, ADDR_W'($urandom_range(0, 31)), '0);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    chk("s2_perf_gnt0", perf_gnt0, 32'd5);
    chk("s2_perf_gnt1", perf_gnt1, 32'd5);
    chk("s2_perf_stall", perf_stall, 32'd10);
`endif
    drive0(0, 0, 0, '0, '0);
    drive1(0, 0, 0, '0, '0);
    step();

    // Locked 4-word write burst from port 1 while port 0 waits to read.
    drive1(1, 1, 1, ADDR_W'(9'h100), 32'hB000_0100);
    step();
    chk("s3_m1_gnt_0", obs_g1, 1'b1);
    drive0(1, 0, 0, ADDR_W'(9'h100), '0);
    for (int i = 1; i < 4; i++) begin
      drive1(1, 1, (i != 3), ADDR_W'(9'h100 + i), 32'hB000_0100 + i);
      step();
      chk($sformatf("s3_m1_gnt_%0d", i), obs_g1, 1'b1);
      chk($sformatf("s3_m0_wait_%0d", i), obs_g0, 1'b0);
    end
    drive1(0, 0, 0, '0, '0);
    step();
    chk("s3_m0_gnt", obs_g0, 1'b1);
    drive0(0, 0, 0, '0, '0);
    step();
    chk("s3_m0_rdata", obs_rd0, 32'hB000_0100);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s3_ram_%0d", i), ram[9'h100 + i], 32'hB000_0100 + i);

    // Lock budget exhaustion: port 0 forced in on the 5th cycle.
    k = 0;
    drive0(1, 0, 0, ADDR_W'(9'h040), '0);
    drive1(1, 1, 1, ADDR_W'(9'h080), 32'hA000_0000);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("s4_m1_gnt_%0d", i), obs_g1, i != 4);
      chk($sformatf("s4_m0_gnt_%0d", i), obs_g0, i == 4);
      if (exp_g1) begin
        k++;
        drive1(1, 1, 1, ADDR_W'(9'h080 + k), 32'hA000_0000 + k);
      end
      if (exp_g0) drive0(1, 0, 0, ADDR_W'(9'h041), '0);
    end
    drive1(0, 0, 0, '0, '0);
    step();
    drive0(0, 0, 0, '0, '0);
    step();

    // Reset lands in the cycle of a port 0 read inside a locked burst.
    drive0(1, 0, 1, ADDR_W'(9'h020), '0);
    step();
    drive0(1, 0, 1, ADDR_W'(9'h021), '0);
    step();
    drive0(1, 0, 1, ADDR_W'(9'h022), '0);
    rst = 1'b1;
    step();
    chk("s5_gnt_in_reset", obs_g0, 1'b1);
    rst = 1'b0;
    drive0(1, 0, 0, ADDR_W'(9'h023), '0);
    drive1(1, 0, 0, ADDR_W'(9'h024), '0);
    step();
    chk("s5_rvalid_after_rst", obs_rv0, 1'b0);
    chk("s5_state_idle", obs_state, 2'd0);
    chk("s5_tie_m0", obs_g0, 1'b1);
    chk("s5_tie_m1", obs_g1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step();
      if (exp_g0 || !m0_req) new_txn(0);
      if (exp_g1 || !m1_req) new_txn(1);
    end
    rst = 1'b0;
    drive0(0, 0, 0, '0, '0);
    drive1(0, 0, 0, '0, '0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
